// File: rtl/dsm_sample_sequencer.sv
// dsm_sample_sequencer
//   Supplies the delta-sigma modulator loop with one PCM sample per slot of
//   2^OSR_LOG2 bit clocks. Output is linearly interpolated between consecutive
//   samples. Mute substitutes zero samples, so the output ramps instead of
//   stepping. An integrator overflow clears the loop and restarts it cleanly.
//
// Ports:
//   BCLK_I       bit clock, rising edge
//   NRST_I       asynchronous active-low reset
//   PCM_DATA_I   signed input sample
//   PCM_VALID_I  input sample valid
//   PCM_READY_O  holding register empty (transfer on VALID & READY)
//   MUTE_I       substitute 0 for consumed samples while high
//   DSM_OVF_I    integrator overflow flag from the modulator
//   DSM_DATA_O   signed interpolated sample to the modulator
//   DSM_CLR_O    integrator clear, held for CLR_CYCLES cycles
//   STROBE_O     last cycle of each slot (RUN only)
//   UNDERRUN_O   slot boundary with no pending sample
//   STATE_O      00 IDLE, 01 RUN, 10 CLEAR
module dsm_sample_sequencer #(
  parameter int PCM_Bit_Length = 32,
  parameter int OSR_LOG2       = 6,
  parameter int CLR_CYCLES     = 4
) (
  input  logic                      BCLK_I,
  input  logic                      NRST_I,
  input  logic [PCM_Bit_Length-1:0] PCM_DATA_I,
  input  logic                      PCM_VALID_I,
  output logic                      PCM_READY_O,
  input  logic                      MUTE_I,
  input  logic                      DSM_OVF_I,
  output logic [PCM_Bit_Length-1:0] DSM_DATA_O,
  output logic                      DSM_CLR_O,
  output logic                      STROBE_O,
  output logic                      UNDERRUN_O,
  output logic [1:0]                STATE_O
);

  localparam int W  = PCM_Bit_Length;
  localparam int DW = W + 1;
  localparam int AW = W + OSR_LOG2 + 1;

  localparam logic [OSR_LOG2-1:0] PH_LAST  = '1;
  localparam logic [OSR_LOG2-1:0] PH_ONE   = OSR_LOG2'(1);
  localparam logic [7:0]          CLR_LOAD = 8'(CLR_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_CLEAR = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [OSR_LOG2-1:0]   phase_q, phase_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [DW-1:0]  delta_q, delta_d;
  logic signed [W-1:0]   next_q, next_d;
  logic signed [W-1:0]   pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [7:0]            clr_cnt_q, clr_cnt_d;

  logic signed [W-1:0]   samp;
  logic signed [DW-1:0]  samp_ext, next_ext;
  logic signed [AW-1:0]  acc_align, delta_ext;
  logic                  boundary;

  // Sample actually fed to the interpolator; mute is applied at consumption.
  assign samp      = MUTE_I ? '0 : pend_q;
  assign samp_ext  = {samp[W-1], samp};
  assign next_ext  = {next_q[W-1], next_q};
  // Re-aligning acc to the target at each boundary removes any drift from
  // the per-phase additions, so phase 0 shows the target exactly.
  assign acc_align = {next_q[W-1], next_q, {OSR_LOG2{1'b0}}};
  assign delta_ext = {{OSR_LOG2{delta_q[DW-1]}}, delta_q};
  assign boundary  = (state_q == S_RUN) && (phase_q == PH_LAST);

  always_ff @(posedge BCLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      acc_q        <= '0;
      delta_q      <= '0;
      next_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      clr_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      acc_q        <= acc_d;
      delta_q      <= delta_d;
      next_q       <= next_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      clr_cnt_q    <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    acc_d        = acc_q;
    delta_d      = delta_q;
    next_d       = next_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    clr_cnt_d    = clr_cnt_q;

    PCM_READY_O  = !pend_valid_q;
    DSM_DATA_O   = '0;
    DSM_CLR_O    = 1'b0;
    STROBE_O     = boundary;
    UNDERRUN_O   = 1'b0;
    STATE_O      = state_q;

    // Transfer and consumption are mutually exclusive: a transfer needs
    // pend_valid low, consumption needs it high.
    if (PCM_VALID_I && !pend_valid_q) begin
      pend_d       = PCM_DATA_I;
      pend_valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_valid_q) begin
          acc_d        = '0;
          next_d       = samp;
          delta_d      = samp_ext;
          pend_valid_d = 1'b0;
          phase_d      = '0;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        // acc_q >>> OSR_LOG2 truncated to W bits is exactly this slice.
        DSM_DATA_O = acc_q[OSR_LOG2 +: W];
        if (DSM_OVF_I) begin
          // Overflow wins over boundary work; the pending word is kept.
          state_d   = S_CLEAR;
          clr_cnt_d = CLR_LOAD;
          acc_d     = '0;
          next_d    = '0;
          delta_d   = '0;
          phase_d   = '0;
        end else if (phase_q == PH_LAST) begin
          acc_d   = acc_align;
          phase_d = '0;
          if (pend_valid_q) begin
            next_d       = samp;
            delta_d      = samp_ext - next_ext;
            pend_valid_d = 1'b0;
          end else begin
            delta_d    = '0;
            UNDERRUN_O = 1'b1;
          end
        end else begin
          acc_d   = acc_q + delta_ext;
          phase_d = phase_q + PH_ONE;
        end
      end
      S_CLEAR: begin
        DSM_CLR_O = 1'b1;
        if (clr_cnt_q <= 8'd1) begin
          state_d = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dsm_sample_sequencer.sv
// Self-checking bench for dsm_sample_sequencer with 16-bit samples, OSR 4
// and a 4-cycle clear. Words to send are queued in stim_q and handed to the
// DUT over VALID/READY; expected per-cycle outputs are queued in exp_q and
// compared one per clock, 1 time unit after the rising edge.
module tb_dsm_sample_sequencer;

  localparam int W = 16;

  logic          BCLK_I = 1'b0;
  logic          NRST_I = 1'b0;
  logic [W-1:0]  PCM_DATA_I = '0;
  logic          PCM_VALID_I = 1'b0;
  logic          PCM_READY_O;
  logic          MUTE_I = 1'b0;
  logic          DSM_OVF_I = 1'b0;
  logic [W-1:0]  DSM_DATA_O;
  logic          DSM_CLR_O;
  logic          STROBE_O;
  logic          UNDERRUN_O;
  logic [1:0]    STATE_O;

  dsm_sample_sequencer #(
    .PCM_Bit_Length(W),
    .OSR_LOG2(2),
    .CLR_CYCLES(4)
  ) dut (
    .BCLK_I(BCLK_I),
    .NRST_I(NRST_I),
    .PCM_DATA_I(PCM_DATA_I),
    .PCM_VALID_I(PCM_VALID_I),
    .PCM_READY_O(PCM_READY_O),
    .MUTE_I(MUTE_I),
    .DSM_OVF_I(DSM_OVF_I),
    .DSM_DATA_O(DSM_DATA_O),
    .DSM_CLR_O(DSM_CLR_O),
    .STROBE_O(STROBE_O),
    .UNDERRUN_O(UNDERRUN_O),
    .STATE_O(STATE_O)
  );

  always #5 BCLK_I = ~BCLK_I;

  typedef struct {
    int         data;
    logic [1:0] st;
    logic       rdy;
    logic       stb;
    logic       und;
    logic       clr;
  } exp_t;

  exp_t exp_q[$];
  int   stim_q[$];
  int   checks = 0;
  int   passed = 0;

  localparam logic [1:0] ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_CLEAR = 2'b10;

  function automatic void push_exp(int d, logic [1:0] st, logic r, logic s, logic u, logic c);
    exp_t e;
    e.data = d; e.st = st; e.rdy = r; e.stb = s; e.und = u; e.clr = c;
    exp_q.push_back(e);
  endfunction

  function automatic logic [5:0] cur_flags();
    return {STATE_O, PCM_READY_O, STROBE_O, UNDERRUN_O, DSM_CLR_O};
  endfunction

  task automatic drive();
    PCM_VALID_I = (stim_q.size() != 0);
    PCM_DATA_I  = (stim_q.size() != 0) ? W'(stim_q[0]) : '0;
  endtask

  // One clock: retire the offered word if it was taken, then offer the next.
  task automatic step();
    logic fire;
    fire = PCM_VALID_I && PCM_READY_O;
    @(posedge BCLK_I);
    #1;
    if (fire) void'(stim_q.pop_front());
    drive();
  endtask

  task automatic do_reset();
    NRST_I = 1'b0;
    PCM_VALID_I = 1'b0;
    PCM_DATA_I = '0;
    MUTE_I = 1'b0;
    DSM_OVF_I = 1'b0;
    stim_q.delete();
    exp_q.delete();
    repeat (2) @(posedge BCLK_I);
    #1 NRST_I = 1'b1;
  endtask

  task automatic test_reset();
    NRST_I = 1'b0;
    PCM_VALID_I = 1'b1;
    PCM_DATA_I = 16'd77;
    repeat (2) @(posedge BCLK_I);
    #1;
    checks++;
    if (DSM_DATA_O !== '0) $display("FAIL reset data: got %0d want 0", $signed(DSM_DATA_O));
    else passed++;
    checks++;
    if (cur_flags() !== 6'b00_1_0_0_0) $display("FAIL reset flags: got %b want 001000", cur_flags());
    else passed++;
    PCM_VALID_I = 1'b0;
  endtask

  task automatic test_underrun_hold();
    int   d[10] = '{0, 0, 2, 4, 6, 8, 8, 8, 8, 8};
    exp_t e;
    do_reset();
    stim_q.push_back(8);
    drive();
    for (int i = 0; i < 10; i++)
      push_exp(d[i], (i == 0) ? ST_IDLE : ST_RUN, i != 0, i == 4 || i == 8, i == 4 || i == 8, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (DSM_DATA_O !== W'(e.data)) $display("FAIL hold data cyc %0d: got %0d want %0d", i, $signed(DSM_DATA_O), e.data);
      else passed++;
      checks++;
      if (cur_flags() !== {e.st, e.rdy, e.stb, e.und, e.clr})
        $display("FAIL hold flags cyc %0d: got %b want %b", i, cur_flags(), {e.st, e.rdy, e.stb, e.und, e.clr});
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int   d[12] = '{0, 0, 2, 4, 6, 8, 4, 0, -4, -8, -8, -8};
    logic r[12] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1};
    exp_t e;
    do_reset();
    stim_q.push_back(8);
    stim_q.push_back(-8);
    stim_q.push_back(-8);
    drive();
    for (int i = 0; i < 12; i++)
      push_exp(d[i], (i == 0) ? ST_IDLE : ST_RUN, r[i], i == 4 || i == 8, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (DSM_DATA_O !== W'(e.data)) $display("FAIL b2b data cyc %0d: got %0d want %0d", i, $signed(DSM_DATA_O), e.data);
      else passed++;
      checks++;
      if (cur_flags() !== {e.st, e.rdy, e.stb, e.und, e.clr})
        $display("FAIL b2b flags cyc %0d: got %b want %b", i, cur_flags(), {e.st, e.rdy, e.stb, e.und, e.clr});
      else passed++;
    end
  endtask

  task automatic test_rounding();
    int   dp[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3};
    int   dn[10] = '{0, 0, 0, 0, 0, 0, -1, -2, -3, -3};
    logic r[10]  = '{0, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    exp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      stim_q.push_back(0);
      stim_q.push_back((pass == 0) ? 3 : -3);
      drive();
      for (int i = 0; i < 10; i++)
        push_exp((pass == 0) ? dp[i] : dn[i], (i == 0) ? ST_IDLE : ST_RUN, r[i], i == 4 || i == 8, i == 8, 1'b0);
      for (int i = 0; i < 10; i++) begin
        step();
        e = exp_q.pop_front();
        checks++;
        if (DSM_DATA_O !== W'(e.data))
          $display("FAIL round%0d data cyc %0d: got %0d want %0d", pass, i, $signed(DSM_DATA_O), e.data);
        else passed++;
        checks++;
        if (cur_flags() !== {e.st, e.rdy, e.stb, e.und, e.clr})
          $display("FAIL round%0d flags cyc %0d: got %b want %b", pass, i, cur_flags(), {e.st, e.rdy, e.stb, e.und, e.clr});
        else passed++;
      end
    end
  endtask

  task automatic test_mute();
    int   d[26] = '{0, 0, 25, 50, 75, 100, 100, 100, 100, 100, 75, 50, 25,
                    0, 0, 0, 0, 0, 0, 0, 0, 0, 25, 50, 75, 100};
    int   ph;
    exp_t e;
    do_reset();
    repeat (7) stim_q.push_back(100);
    drive();
    for (int i = 0; i < 26; i++) begin
      ph = (i + 3) % 4;
      push_exp(d[i], (i == 0) ? ST_IDLE : ST_RUN, i != 0 && ph == 0, i != 0 && ph == 3, 1'b0, 1'b0);
    end
    for (int c = 0; c < 26; c++) begin
      MUTE_I = (c >= 9 && c <= 17);
      step();
      e = exp_q.pop_front();
      checks++;
      if (DSM_DATA_O !== W'(e.data)) $display("FAIL mute data cyc %0d: got %0d want %0d", c, $signed(DSM_DATA_O), e.data);
      else passed++;
      checks++;
      if (cur_flags() !== {e.st, e.rdy, e.stb, e.und, e.clr})
        $display("FAIL mute flags cyc %0d: got %b want %b", c, cur_flags(), {e.st, e.rdy, e.stb, e.und, e.clr});
      else passed++;
    end
    MUTE_I = 1'b0;
  endtask

  task automatic test_overflow();
    int         d[13]  = '{0, 0, 5, 0, 0, 0, 0, 0, 0, 10, 20, 30, 40};
    logic [1:0] st[13] = '{ST_IDLE, ST_RUN, ST_RUN, ST_CLEAR, ST_CLEAR, ST_CLEAR, ST_CLEAR,
                           ST_IDLE, ST_RUN, ST_RUN, ST_RUN, ST_RUN, ST_RUN};
    exp_t e;
    do_reset();
    stim_q.push_back(20);
    stim_q.push_back(40);
    drive();
    for (int i = 0; i < 13; i++)
      push_exp(d[i], st[i], i == 1 || i >= 8, i == 11, i == 11, i >= 3 && i <= 6);
    for (int c = 0; c < 13; c++) begin
      DSM_OVF_I = (c == 3);
      step();
      e = exp_q.pop_front();
      checks++;
      if (DSM_DATA_O !== W'(e.data)) $display("FAIL ovf data cyc %0d: got %0d want %0d", c, $signed(DSM_DATA_O), e.data);
      else passed++;
      checks++;
      if (cur_flags() !== {e.st, e.rdy, e.stb, e.und, e.clr})
        $display("FAIL ovf flags cyc %0d: got %b want %b", c, cur_flags(), {e.st, e.rdy, e.stb, e.und, e.clr});
      else passed++;
    end
    DSM_OVF_I = 1'b0;
  endtask

  task automatic test_reset_midramp();
    int   d1[4] = '{0, 0, 10, 20};
    int   d2[6] = '{0, 0, 2, 4, 6, 8};
    exp_t e;
    do_reset();
    stim_q.push_back(40);
    drive();
    for (int i = 0; i < 4; i++)
      push_exp(d1[i], (i == 0) ? ST_IDLE : ST_RUN, i != 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (DSM_DATA_O !== W'(e.data)) $display("FAIL midrst pre data cyc %0d: got %0d want %0d", i, $signed(DSM_DATA_O), e.data);
      else passed++;
      checks++;
      if (cur_flags() !== {e.st, e.rdy, e.stb, e.und, e.clr})
        $display("FAIL midrst pre flags cyc %0d: got %b want %b", i, cur_flags(), {e.st, e.rdy, e.stb, e.und, e.clr});
      else passed++;
    end
    // Asynchronous assertion between clock edges, at phase 2.
    #1 NRST_I = 1'b0;
    #1;
    checks++;
    if (DSM_DATA_O !== '0) $display("FAIL midrst data: got %0d want 0", $signed(DSM_DATA_O));
    else passed++;
    checks++;
    if (cur_flags() !== 6'b00_1_0_0_0) $display("FAIL midrst flags: got %b want 001000", cur_flags());
    else passed++;
    do_reset();
    stim_q.push_back(8);
    drive();
    for (int i = 0; i < 6; i++)
      push_exp(d2[i], (i == 0) ? ST_IDLE : ST_RUN, i != 0, i == 4, i == 4, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (DSM_DATA_O !== W'(e.data)) $display("FAIL midrst post data cyc %0d: got %0d want %0d", i, $signed(DSM_DATA_O), e.data);
      else passed++;
      checks++;
      if (cur_flags() !== {e.st, e.rdy, e.stb, e.und, e.clr})
        $display("FAIL midrst post flags cyc %0d: got %b want %b", i, cur_flags(), {e.st, e.rdy, e.stb, e.und, e.clr});
      else passed++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_underrun_hold();
    test_back_to_back();
    test_rounding();
    test_mute();
    test_overflow();
    test_reset_midramp();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dsm_sample_sequencer.md
Name: dsm_sample_sequencer

Overview:
- Feeds the delta-sigma modulator loop with one PCM sample every 2^OSR_LOG2 bit clocks.
- Upstream samples arrive over a VALID/READY handshake into a one-entry holding register.
- The output is linearly interpolated between consecutive samples. Mute is done by substituting zero samples, so the interpolator ramps the signal down or up with no step.
- On integrator overflow reported by the loop, the block clears the integrators and restarts cleanly.

Parameters:
PCM_Bit_Length, 32, signed PCM sample width
OSR_LOG2, 6, log2 of bit clocks per sample slot (OSR = 2^OSR_LOG2)
CLR_CYCLES, 4, number of cycles DSM_CLR_O is held high after an overflow (1..255)

Ports:
BCLK_I  in  1  bit clock; all state changes on its rising edge
NRST_I  in  1  reset, asynchronous, active-low
PCM_DATA_I  in  PCM_Bit_Length  signed input sample
PCM_VALID_I  in  1  input sample valid
PCM_READY_O  out  1  holding register empty; transfer happens when VALID&READY
MUTE_I  in  1  substitute 0 for consumed samples while high
DSM_OVF_I  in  1  overflow flag from the modulator integrators
DSM_DATA_O  out  PCM_Bit_Length  signed interpolated sample to the modulator
DSM_CLR_O  out  1  integrator clear
STROBE_O  out  1  high on the last cycle of each slot (RUN only)
UNDERRUN_O  out  1  one-cycle pulse at a slot boundary with no pending sample
STATE_O  out  2  00 IDLE, 01 RUN, 10 CLEAR

Behaviour:
- Reset (async, NRST_I low): state IDLE; phase, acc, delta, next, pend all 0; pend_valid 0.
- Outputs during reset: DSM_DATA_O 0, DSM_CLR_O 0, STROBE_O 0, UNDERRUN_O 0, PCM_READY_O 1.
- A reset applied mid-slot abandons all state immediately.
- Holding register:
  - PCM_READY_O = !pend_valid.
  - A transfer loads pend and sets pend_valid.
  - A word accepted in a slot's boundary cycle is not consumed until the following boundary.
- Internal widths:
  - next and pend: PCM_Bit_Length.
  - delta: PCM_Bit_Length+1 signed.
  - acc: PCM_Bit_Length+OSR_LOG2+1 signed.
  - phase: OSR_LOG2 bits.
- Output: DSM_DATA_O = acc >>> OSR_LOG2, an arithmetic shift (floor), truncated to PCM_Bit_Length. No extra register delay after acc.
- Sample substitution: s = MUTE_I ? 0 : pend, with MUTE_I sampled in the consuming cycle. Muted samples are still consumed.
- IDLE:
  - phase = 0, DSM_DATA_O = 0.
  - When pend_valid=1: acc <= 0, next <= s, delta <= s, pend_valid <= 0, phase <= 0, go to RUN.
  - DSM_OVF_I is ignored.
- RUN, phase < OSR-1: acc <= acc + delta, phase++.
- RUN, phase == OSR-1 (boundary cycle, STROBE_O=1):
  - acc <= next << OSR_LOG2 (exact re-alignment), phase <= 0.
  - If pend_valid: next <= s, delta <= s - next, pend_valid <= 0.
  - Else: next and delta are held with delta <= 0 (flat hold), and UNDERRUN_O = 1 in this cycle.
- Resulting slot output: at phase k, floor((cur*OSR + k*(next-cur)) / OSR), k = 0..OSR-1.
- RUN, DSM_DATA_O at phase 0 of each slot equals the previous target sample exactly.
- DSM_OVF_I sampled high in RUN (takes priority over boundary actions): go to CLEAR.
  - Load a counter with CLR_CYCLES.
  - acc, next, delta, phase <= 0.
  - pend and pend_valid are untouched.
- CLEAR:
  - DSM_CLR_O = 1 and DSM_DATA_O = 0 for exactly CLR_CYCLES cycles, then go to IDLE.
  - The handshake keeps operating. DSM_OVF_I is ignored.
- IDLE re-entry after CLEAR: if pend_valid is already 1, RUN starts on the next cycle and ramps from 0.
- Simultaneous events:
  - Overflow in a boundary cycle: the boundary is skipped and the pending sample is retained.
  - Transfer in the same cycle as consumption: not possible, because READY is low while pend_valid=1.

Test Plan (PCM_Bit_Length=16, OSR_LOG2=2, CLR_CYCLES=4):
- Reset, send 8 then nothing -> DSM_DATA_O 0,2,4,6 then 8 held; UNDERRUN_O pulses once per slot thereafter; STATE_O 01.
- Stream 8, -8 back-to-back -> after reaching 8: 8,4,0,-4,-8; no UNDERRUN_O; PCM_READY_O low from acceptance to the consuming boundary.
- Rounding: 0->3 gives 0,0,1,2,3; 0->-3 gives 0,-1,-2,-3,-3 (floor); STROBE_O high only on phase 3.
- Stream of 100 with MUTE_I raised before a boundary -> 100,75,50,25,0 then 0; words still consumed; release MUTE_I -> 0,25,50,75,100.
- DSM_OVF_I pulse mid-slot with pend holding 40 -> STATE_O 10 and DSM_CLR_O high exactly 4 cycles with DSM_DATA_O 0; then IDLE; then RUN ramping 0,10,20,30,40.
- NRST_I low at phase 2 of an active ramp -> all outputs 0 immediately, PCM_READY_O 1, STATE_O 00; normal ramp after release.
